// File: rtl/mac_pkg.sv
// Shared constants and saturating-arithmetic helpers for the MAC and future adder-tree blocks.
// The helpers operate on a 64-bit signed carrier, so any accumulator up to 62 bits wide fits without loss.
package mac_pkg;

  localparam int DEF_IN_W        = 14;
  localparam int DEF_ACC_W       = 28;
  localparam int DEF_MULT_STAGES = 5;
  localparam int MAX_W           = 64;

  typedef logic signed [MAX_W-1:0] wide_t;

  typedef struct packed {
    logic signed [MAX_W-1:0] sum;
    logic                    sat_now;
  } sat_sum_t;

  function automatic wide_t sat_max(input int width);
    wide_t one;
    one = 64'sd1;
    return (one <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic wide_t sat_min(input int width);
    return ~sat_max(width);
  endfunction

  // Operands are sign-extended width-bit values, so the 64-bit sum cannot overflow.
  // Comparing against the width-bit limits detects both same-sign overflow cases.
  function automatic sat_sum_t sat_add(input wide_t x, input wide_t y, input int width);
    sat_sum_t r;
    wide_t    s;
    s         = x + y;
    r.sum     = s;
    r.sat_now = 1'b0;
    if (s > sat_max(width)) begin
      r.sum     = sat_max(width);
      r.sat_now = 1'b1;
    end else if (s < sat_min(width)) begin
      r.sum     = sat_min(width);
      r.sat_now = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_pipe.sv
// Signed full-precision multiplier: a combinational multiply followed by MULT_STAGES registers.
// The stages have no reset; the valid tag in the parent decides when the output is used.
module mult_pipe
  import mac_pkg::*;
#(
  parameter int IN_W        = DEF_IN_W,
  parameter int MULT_STAGES = DEF_MULT_STAGES
) (
  input  logic                   clk,
  input  logic signed [IN_W-1:0] a,
  input  logic signed [IN_W-1:0] b,
  output logic signed [2*IN_W-1:0] p
);

  logic signed [2*IN_W-1:0] stage [MULT_STAGES];

  always_ff @(posedge clk) begin
    stage[0] <= (2*IN_W)'(a) * (2*IN_W)'(b);
    for (int i = 1; i < MULT_STAGES; i++) begin
      stage[i] <= stage[i-1];
    end
  end

  assign p = stage[MULT_STAGES-1];

endmodule

// File: rtl/mac_pipe_param.sv
// Pipelined signed multiply-accumulate with saturation and an optional dot-product mode.
// valid_in is a one-cycle qualifier with no backpressure; valid_out pulses for one cycle per result.
module mac_pipe_param
  import mac_pkg::*;
#(
  parameter int IN_W        = DEF_IN_W,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int MULT_STAGES = DEF_MULT_STAGES,
  parameter int VEC_LEN     = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [IN_W-1:0]  b,
  input  logic                    valid_in,
  output logic signed [ACC_W-1:0] f,
  output logic                    valid_out,
  output logic                    sat
);

  localparam int CNT_W = (VEC_LEN > 0) ? $clog2(VEC_LEN) + 1 : 1;

  if (ACC_W < 2*IN_W || ACC_W > MAX_W - 2 || MULT_STAGES < 1 || MULT_STAGES > 8 || VEC_LEN < 0) begin : g_bad_params
    $error("mac_pipe_param: illegal parameter combination");
  end

  logic signed [IN_W-1:0]   a_r, b_r;
  logic signed [2*IN_W-1:0] p;
  logic signed [ACC_W-1:0]  prod_r;
  logic [MULT_STAGES+1:0]   vld;
  logic [CNT_W-1:0]         cnt;
  logic                     sticky;

  logic                     vec_start, vec_end, sticky_next;
  logic signed [ACC_W-1:0]  acc_base;
  sat_sum_t                 add_res;

  mult_pipe #(.IN_W(IN_W), .MULT_STAGES(MULT_STAGES)) u_mult (
    .clk (clk),
    .a   (a_r),
    .b   (b_r),
    .p   (p)
  );

  always_comb begin
    vec_start   = (VEC_LEN != 0) && (cnt == '0);
    vec_end     = (VEC_LEN != 0) && (cnt == CNT_W'(VEC_LEN - 1));
    acc_base    = vec_start ? '0 : f;
    add_res     = sat_add(MAX_W'(acc_base), MAX_W'(prod_r), ACC_W);
    sticky_next = (vec_start ? 1'b0 : sticky) | add_res.sat_now;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_r       <= '0;
      b_r       <= '0;
      prod_r    <= '0;
      vld       <= '0;
      cnt       <= '0;
      sticky    <= 1'b0;
      f         <= '0;
      valid_out <= 1'b0;
      sat       <= 1'b0;
    end else begin
      if (valid_in) begin
        a_r <= a;
        b_r <= b;
      end
      vld       <= {vld[MULT_STAGES:0], valid_in};
      valid_out <= 1'b0;
      if (vld[MULT_STAGES]) begin
        prod_r <= ACC_W'(p);
      end
      if (vld[MULT_STAGES+1]) begin
        f <= add_res.sum[ACC_W-1:0];
        if (VEC_LEN == 0) begin
          valid_out <= 1'b1;
          sat       <= add_res.sat_now;
        end else begin
          // f shows the running partial sum; status is published only at the vector end
          sticky <= sticky_next;
          if (vec_end) begin
            valid_out <= 1'b1;
            sat       <= sticky_next;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_pipe_param.sv
// Bench for mac_pipe_param: default, dot-product and narrow instances checked against a cycle model.
module tb_mac_pipe_param;

  logic clk = 1'b0;
  logic reset;
  logic signed [13:0] a, b;
  logic valid_in;
  logic signed [7:0] a8, b8;
  assign a8 = a[7:0];
  assign b8 = b[7:0];

  logic signed [27:0] f0, f4;
  logic vo0, vo4, sat0, sat4;
  logic signed [15:0] f1, f8;
  logic vo1, vo8, sat1, sat8;

  mac_pipe_param u0 (.clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in),
                     .f(f0), .valid_out(vo0), .sat(sat0));
  mac_pipe_param #(.VEC_LEN(4)) u4 (.clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in),
                     .f(f4), .valid_out(vo4), .sat(sat4));
  mac_pipe_param #(.IN_W(8), .ACC_W(16), .MULT_STAGES(1)) u1 (.clk(clk), .reset(reset), .a(a8), .b(b8),
                     .valid_in(valid_in), .f(f1), .valid_out(vo1), .sat(sat1));
  mac_pipe_param #(.IN_W(8), .ACC_W(16), .MULT_STAGES(8)) u8 (.clk(clk), .reset(reset), .a(a8), .b(b8),
                     .valid_in(valid_in), .f(f8), .valid_out(vo8), .sat(sat8));

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  int sel, lat_s, vecn, accw;

  longint st_a[64], st_b[64];
  bit     st_v[64];
  int     n_st;

  longint obs_q[$];
  bit     obs_sat_q[$];
  longint exp_q[$];
  bit     exp_sat_q[$];

  typedef struct {
    longint a;
    longint b;
    longint f;
    bit     sat;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cfg(input int id);
    sel = id;
    case (id)
      0:       begin lat_s = 5; vecn = 0; accw = 28; end
      1:       begin lat_s = 5; vecn = 4; accw = 28; end
      2:       begin lat_s = 1; vecn = 0; accw = 16; end
      default: begin lat_s = 8; vecn = 0; accw = 16; end
    endcase
  endtask

  task automatic sample(output longint fv, output bit vo, output bit sv);
    case (sel)
      0:       begin fv = longint'(f0); vo = vo0; sv = sat0; end
      1:       begin fv = longint'(f4); vo = vo4; sv = sat4; end
      2:       begin fv = longint'(f1); vo = vo1; sv = sat1; end
      default: begin fv = longint'(f8); vo = vo8; sv = sat8; end
    endcase
  endtask

  // driver tasks
  task automatic do_reset();
    longint fv;
    bit vo, sv;
    reset = 1'b1; valid_in = 1'b0; a = '0; b = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sample(fv, vo, sv);
    chk("reset_f", fv, 0);
    chk("reset_vo", longint'(vo), 0);
    chk("reset_sat", longint'(sv), 0);
  endtask

  task automatic push_pair(input bit v, input longint pa, input longint pb);
    st_v[n_st] = v; st_a[n_st] = pa; st_b[n_st] = pb;
    n_st++;
  endtask

  // Applies the loaded stimulus and checks every cycle against an arithmetic model.
  task automatic run_seq(input string tag);
    longint fm, mx, mn, base, s, fv;
    int cnt, j;
    bit stick, sm, sn, vo_e, vo, sv;
    fm = 0; cnt = 0; stick = 0; sm = 0;
    mx = (64'sd1 <<< (accw - 1)) - 1;
    mn = -mx - 1;
    do_reset();
    obs_q.delete(); obs_sat_q.delete();
    for (int k = 0; k < n_st + lat_s + 3; k++) begin
      if (k < n_st) begin
        valid_in = st_v[k]; a = 14'(st_a[k]); b = 14'(st_b[k]);
      end else begin
        valid_in = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      j = k - lat_s - 2;
      vo_e = 0;
      if (j >= 0 && j < n_st && st_v[j]) begin
        base = (vecn != 0 && cnt == 0) ? 0 : fm;
        s = base + st_a[j] * st_b[j];
        sn = 0;
        if (s > mx) begin s = mx; sn = 1; end
        else if (s < mn) begin s = mn; sn = 1; end
        fm = s;
        if (vecn == 0) begin
          vo_e = 1; sm = sn;
        end else begin
          stick = (cnt == 0 ? 1'b0 : stick) | sn;
          cnt++;
          if (cnt == vecn) begin vo_e = 1; sm = stick; cnt = 0; end
        end
      end
      sample(fv, vo, sv);
      chk({tag, "_f"}, fv, fm);
      chk({tag, "_vo"}, longint'(vo), longint'(vo_e));
      if (vo_e) chk({tag, "_sat"}, longint'(sv), longint'(sm));
      if (vo) begin obs_q.push_back(fv); obs_sat_q.push_back(sv); end
    end
  endtask

  // scoreboard: observed valid_out results against the expected queue
  task automatic check_exp(input string tag);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) begin
        chk({tag, "_res"}, obs_q[i], exp_q[i]);
        chk({tag, "_res_sat"}, longint'(obs_sat_q[i]), longint'(exp_sat_q[i]));
      end
    end
    exp_q.delete(); exp_sat_q.delete();
  endtask

  task automatic idle_check(input string tag, input int cycles);
    longint fv;
    bit vo, sv;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      @(negedge clk);
      sample(fv, vo, sv);
      chk({tag, "_vo"}, longint'(vo), 0);
      chk({tag, "_f"}, fv, 0);
    end
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; a = '0; b = '0;
    tbl[0] = '{3, 4, 12, 0};
    tbl[1] = '{-5, 7, -35, 0};
    tbl[2] = '{-8192, -8192, 67108864, 0};
    tbl[3] = '{8191, -8192, -67100672, 0};
    tbl[4] = '{0, -77, 0, 0};
    tbl[5] = '{8191, 8191, 67092481, 0};
    tbl[6] = '{2, 3, 6, 0};

    // single pairs: latency, value and one-cycle valid_out
    cfg(0);
    for (int i = 0; i < 7; i++) begin
      n_st = 0;
      push_pair(1, tbl[i].a, tbl[i].b);
      run_seq("single");
      exp_q.push_back(tbl[i].f); exp_sat_q.push_back(tbl[i].sat);
      check_exp("single");
    end

    // back-to-back, then a bubble pattern
    n_st = 0;
    for (int i = 0; i < 4; i++) push_pair(1, 2, 2);
    push_pair(1, 5, 5); push_pair(0, 5, 5); push_pair(1, 5, 5);
    run_seq("b2b");
    exp_q = '{4, 8, 12, 16, 41, 66}; exp_sat_q = '{0, 0, 0, 0, 0, 0};
    check_exp("b2b");

    // positive then negative saturation
    n_st = 0;
    for (int i = 0; i < 3; i++) push_pair(1, -8192, -8192);
    run_seq("satpos");
    exp_q = '{67108864, 134217727, 134217727}; exp_sat_q = '{0, 1, 1};
    check_exp("satpos");
    n_st = 0;
    for (int i = 0; i < 8; i++) push_pair(1, -8192, 8191);
    run_seq("satneg");
    exp_q = '{-67100672, -134201344, -134217728, -134217728, -134217728, -134217728, -134217728, -134217728};
    exp_sat_q = '{0, 0, 1, 1, 1, 1, 1, 1};
    check_exp("satneg");

    // dot product of length 4
    cfg(1);
    n_st = 0;
    for (int i = 1; i <= 8; i++) push_pair(1, i, i);
    run_seq("dot");
    exp_q = '{30, 174}; exp_sat_q = '{0, 0};
    check_exp("dot");

    // reset while a pair is in flight
    cfg(0);
    do_reset();
    valid_in = 1'b1; a = 14'sd100; b = 14'sd100;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle_check("midreset", 10);

    // reset and valid_in together: the pair is dropped
    reset = 1'b1; valid_in = 1'b1; a = 14'sd9; b = 14'sd9;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; valid_in = 1'b0;
    idle_check("resetwins", 10);

    // narrow instances with short and long multiplier pipelines
    for (int id = 2; id <= 3; id++) begin
      cfg(id);
      n_st = 0;
      push_pair(1, 3, 4);
      run_seq("narrow");
      exp_q = '{12}; exp_sat_q = '{0};
      check_exp("narrow");
      n_st = 0;
      for (int i = 0; i < 30; i++)
        push_pair($urandom_range(0, 3) != 0, longint'($urandom_range(0, 255)) - 128,
                  longint'($urandom_range(0, 255)) - 128);
      run_seq("narrow_rand");
    end

    // random full-range stimulus on both wide instances
    n_st = 0;
    for (int i = 0; i < 48; i++)
      push_pair($urandom_range(0, 3) != 0, longint'($urandom_range(0, 16383)) - 8192,
                longint'($urandom_range(0, 16383)) - 8192);
    cfg(0);
    run_seq("rand_free");
    cfg(1);
    run_seq("rand_dot");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
